// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a bounded ownership time.
// One owner at a time drives the bus. Every release is followed by a
// one-cycle turnaround (GAP) and one arbitration cycle (IDLE), so there are
// at least two grant-free cycles between owners.
// All outputs come straight from registers.
module bus_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [3:0]      hold_cnt_reg, hold_cnt_next;
  logic [N-1:0]    grant_reg, grant_next;
  logic [IW-1:0]   grant_id_reg, grant_id_next;
  logic            busy_reg, busy_next;
  logic            timeout_reg, timeout_next;

  // Requests rotated so that position 0 is the requester at ptr.
  logic [N-1:0]    req_rot;
  logic [IW-1:0]   rot_idx [N];
  logic [IW-1:0]   win_off;
  logic [IW-1:0]   winner;
  logic            any_req;
  logic            owner_req;
  logic            hold_max;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      assign rot_idx[gi] = ptr_reg + IW'(gi);
      assign req_rot[gi] = req[rot_idx[gi]];
    end
  endgenerate

  // Lowest set position of the rotated vector is the round-robin winner.
  always_comb begin
    win_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_off = IW'(k);
      end
    end
  end

  assign any_req   = |req_rot;
  assign winner    = ptr_reg + win_off;
  assign owner_req = req[grant_id_reg];
  assign hold_max  = (hold_cnt_reg == 4'(MAX_HOLD));

  // State and output registers; clr is active low and synchronous.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Next-state: arbitrate in IDLE, release on drop or hold limit, one GAP.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = OWN;
      OWN:     if (!owner_req || hold_max) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and hold counter.
  // A dropped request wins over the hold limit, so it never pulses timeout.
  always_comb begin
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    busy_next     = busy_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next    = {{(N-1){1'b0}}, 1'b1} << winner;
          grant_id_next = winner;
          busy_next     = 1'b1;
          hold_cnt_next = 4'd1;
          ptr_next      = winner + IW'(1);
        end else begin
          grant_next = '0;
          busy_next  = 1'b0;
        end
      end
      OWN: begin
        if (!owner_req) begin
          grant_next = '0;
          busy_next  = 1'b0;
        end else if (hold_max) begin
          grant_next   = '0;
          busy_next    = 1'b0;
          timeout_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end
      default: begin
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign grant    = grant_reg;
  assign grant_id = grant_id_reg;
  assign busy     = busy_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios followed by random requests,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_bus_arbiter;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Reference model: current owner (-1 = none), cycles owned so far,
  // grant-free cycles still to elapse before arbitration, next-first index.
  int   m_owner = -1;
  int   m_held  = 0;
  int   m_quiet = 0;
  int   m_ptr   = 0;
  bit   m_tmo   = 1'b0;
  logic [7:0] prev_grant = 8'h00;

  bus_arbiter #(.N(8), .MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic step(input logic [7:0] r, input logic c);
    int w;
    @(negedge clk);
    req = r;
    clr = c;
    @(posedge clk);
    m_tmo = 1'b0;
    if (!c) begin
      m_owner = -1; m_held = 0; m_quiet = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_quiet = 1;
      end else if (m_held == MAXH) begin
        m_owner = -1; m_quiet = 1; m_tmo = 1'b1;
      end else begin
        m_held++;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else begin
      w = -1;
      for (int k = 0; k < 8; k++) begin
        if (w < 0 && r[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      end
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_ptr = (w + 1) % 8;
      end
    end
    #1;
    chk("grant", grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("busy", busy, (m_owner >= 0) ? 1 : 0);
    chk("timeout", timeout, m_tmo);
    chk("onehot0", $onehot0(grant), 1);
    if (m_owner >= 0) chk("grant_id", grant_id, m_owner);
    if (grant !== prev_grant)
      $display("t=%0t req=%02h grant=%02h id=%0d busy=%0b timeout=%0b",
               $time, r, grant, grant_id, busy, timeout);
    prev_grant = grant;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b1);
  endtask

  initial begin
    logic [7:0] r;
    logic       c;

    // Reset state
    step(8'h00, 1'b0);
    step(8'hFF, 1'b0);
    chk("rst_grant", grant, 8'h00);
    chk("rst_grant_id", grant_id, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ptr", dut.ptr_reg, 3'd0);

    // Single requester 0: granted on the next edge, ptr moves to 1
    step(8'h01, 1'b1);
    chk("s30_grant", grant, 8'h01);
    chk("s30_id", grant_id, 3'd0);
    chk("s30_busy", busy, 1'b1);
    chk("s30_ptr", dut.ptr_reg, 3'd1);
    idle_cycles(3);

    // All requesting: 4 cycles each, 2 gap cycles, timeout per release
    step(8'h00, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step(8'hFF, 1'b1);
      if (i == 0) chk("s31_first", grant, 8'h01);
      if (i == 3) chk("s31_hold4", grant, 8'h01);
      if (i == 4) chk("s31_tmo", {grant, timeout}, {8'h00, 1'b1});
      if (i == 5) chk("s31_gap2", {grant, timeout}, {8'h00, 1'b0});
      if (i == 6) chk("s31_second", grant, 8'h02);
      if (i == 12) chk("s31_third", grant, 8'h04);
    end
    idle_cycles(3);

    // Voluntary release after 2 granted cycles
    step(8'h00, 1'b0);
    step(8'h08, 1'b1);
    step(8'h08, 1'b1);
    chk("s32_held", grant, 8'h08);
    step(8'h00, 1'b1);
    chk("s32_rel", {grant, timeout}, {8'h00, 1'b0});
    idle_cycles(2);

    // Drop on the same edge the hold limit is reached: no timeout
    step(8'h02, 1'b1);
    step(8'h02, 1'b1);
    step(8'h02, 1'b1);
    step(8'h02, 1'b1);
    step(8'h00, 1'b1);
    chk("s20_notmo", {grant, timeout}, {8'h00, 1'b0});
    idle_cycles(2);

    // Wrap-around: grant 6 (ptr=7), then 8'h81 grants 7 before 0
    step(8'h00, 1'b0);
    step(8'h40, 1'b1);
    chk("s33_six", grant, 8'h40);
    chk("s33_ptr", dut.ptr_reg, 3'd7);
    idle_cycles(2);
    for (int i = 0; i < 8; i++) begin
      step(8'h81, 1'b1);
      if (i == 0) chk("s33_seven", grant, 8'h80);
      if (i == 6) chk("s33_zero", grant, 8'h01);
    end
    idle_cycles(4);

    // Reset mid-ownership, then arbitration restarts from 0
    step(8'h10, 1'b1);
    chk("s34_own", grant, 8'h10);
    step(8'h10, 1'b0);
    chk("s34_clr", {grant, busy, timeout}, {8'h00, 1'b0, 1'b0});
    chk("s34_ptr", dut.ptr_reg, 3'd0);
    step(8'h30, 1'b1);
    chk("s34_first", grant, 8'h10);
    idle_cycles(3);

    // Lone requester held: 4 cycles, timeout, 2 idle, re-granted
    step(8'h00, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(8'h04, 1'b1);
      if (i == 3) chk("s35_hold", grant, 8'h04);
      if (i == 4) chk("s35_tmo", {grant, timeout}, {8'h00, 1'b1});
      if (i == 5) chk("s35_idle", grant, 8'h00);
      if (i == 6) chk("s35_regrant", grant, 8'h04);
    end
    idle_cycles(3);

    // Random requests with occasional reset
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'h01 << $urandom_range(0, 7);
        default: r = 8'($urandom);
      endcase
      c = ($urandom_range(0, 39) != 0);
      step(r, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
